// File: rtl/game_tick_gen.sv
// Game tick generator: speed-selected clock divider producing one-cycle ticks.
// Define ROUND_TIMER_EN to add the round countdown, the DONE state and round_done.
module game_tick_gen #(
  parameter int TICK_NORMAL = 50000000,
  parameter int TICK_INTER  = 25000000,
  parameter int TICK_ADV    = 12500000,
  parameter int ROUND_TICKS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic       user_log,
  input  logic       start,
  input  logic       pause,
  output logic       tick,
  output logic       busy,
  output logic       round_done,
  output logic [5:0] ticks_left,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_RUN    = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

`ifdef ROUND_TIMER_EN
  localparam bit TIMER_EN = 1'b1;
`else
  localparam bit TIMER_EN = 1'b0;
`endif

  // Without the round timer the countdown register is simply held at zero.
  localparam logic [5:0] ROUND_LOAD = TIMER_EN ? 6'(ROUND_TICKS) : 6'd0;

  state_t      state_q, state_d;
  logic [1:0]  speed_q, speed_d;
  logic [25:0] div_q, div_d;
  logic [5:0]  left_q, left_d;
  logic        tick_q, tick_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [25:0] period_m1;
  logic        div_wrap;
  logic        tick_fire;

  always_comb begin
    case (speed_q)
      2'b01:   period_m1 = 26'(TICK_INTER - 1);
      2'b10:   period_m1 = 26'(TICK_ADV - 1);
      default: period_m1 = 26'(TICK_NORMAL - 1);
    endcase
  end

  assign div_wrap = (div_q >= period_m1);

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      speed_q <= 2'b00;
      div_q   <= '0;
      left_q  <= '0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      speed_q <= speed_d;
      div_q   <= div_d;
      left_q  <= left_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; losing user_log outranks everything except reset.
  always_comb begin
    state_d   = state_q;
    speed_d   = speed_q;
    div_d     = div_q;
    left_d    = left_q;
    tick_fire = 1'b0;
    if (state_q != S_IDLE && !user_log) begin
      state_d = S_IDLE;
      div_d   = '0;
      left_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (user_log) begin
            speed_d = speed;
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (start) begin
            div_d   = '0;
            left_d  = ROUND_LOAD;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (div_wrap) begin
            tick_fire = 1'b1;
            div_d     = '0;
`ifdef ROUND_TIMER_EN
            if (left_q <= 6'd1) begin
              left_d  = '0;
              state_d = S_DONE;
            end else begin
              left_d = left_q - 6'd1;
            end
`endif
          end else begin
            div_d = div_q + 26'd1;
          end
        end
        S_PAUSED: begin
          if (!pause) state_d = S_RUN;
        end
`ifdef ROUND_TIMER_EN
        S_DONE: begin
          if (start) begin
            div_d   = '0;
            left_d  = ROUND_LOAD;
            state_d = S_RUN;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          speed_d = 2'b00;
          div_d   = '0;
          left_d  = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    tick_d = tick_fire;
    busy_d = (state_d == S_RUN) || (state_d == S_PAUSED);
    done_d = TIMER_EN && (state_d == S_DONE);
  end

  assign tick       = tick_q;
  assign busy       = busy_q;
  assign round_done = done_q;
  assign ticks_left = left_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Bench for game_tick_gen with small periods (4/3/2) and 3-tick rounds.
module tb_game_tick_gen;

  localparam int TN = 4;
  localparam int TI = 3;
  localparam int TA = 2;
  localparam int RT = 3;

`ifdef ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       user_log = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] speed = 2'b00;
  logic       tick;
  logic       busy;
  logic       round_done;
  logic [5:0] ticks_left;
  logic [2:0] dbg_state;

  game_tick_gen #(
    .TICK_NORMAL(TN),
    .TICK_INTER (TI),
    .TICK_ADV   (TA),
    .ROUND_TICKS(RT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .speed     (speed),
    .user_log  (user_log),
    .start     (start),
    .pause     (pause),
    .tick      (tick),
    .busy      (busy),
    .round_done(round_done),
    .ticks_left(ticks_left),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard
  logic [8:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       r;
    logic       ul;
    logic [1:0] sp;
    logic       st;
    logic       pa;
    logic       et;
    logic       eb;
    logic       ed;
    logic [5:0] el;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [5:0] lft(input int n);
    return TIMER ? 6'(n) : 6'd0;
  endfunction

  function automatic vec_t mk(input logic r, input logic ul, input logic [1:0] sp,
                              input logic st, input logic pa, input logic et,
                              input logic eb, input logic ed, input logic [5:0] el);
    vec_t v;
    v.r = r; v.ul = ul; v.sp = sp; v.st = st; v.pa = pa;
    v.et = et; v.eb = eb; v.ed = ed; v.el = el;
    return v;
  endfunction

  task automatic check(input string name);
    logic [8:0] e;
    logic [8:0] g;
    e = exp_q.pop_front();
    g = {tick, busy, round_done, ticks_left};
    total++;
    if (g !== e) begin
      bad++;
      $display("FAIL %s: got tick=%b busy=%b done=%b left=%0d, expected tick=%b busy=%b done=%b left=%0d (state=%0d)",
               name, g[8], g[7], g[6], g[5:0], e[8], e[7], e[6], e[5:0], dbg_state);
    end
  endtask

  // Driver: apply one cycle of inputs, queue the expected outputs, check after the edge.
  task automatic cyc(input logic r, input logic ul, input logic [1:0] sp,
                     input logic st, input logic pa, input logic et,
                     input logic eb, input logic ed, input logic [5:0] el,
                     input string name);
    rst = r; user_log = ul; speed = sp; start = st; pause = pa;
    exp_q.push_back({et, eb, ed, el});
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    int n;
    int nt;

    // Table: reset, latch speed 10, ignored speed change, first round at period 2.
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 6'd0));
    tbl.push_back(mk(1, 1, 2'b10, 0, 0, 0, 0, 0, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 0, 0, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 1, 0, 0, 1, 0, lft(3)));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 1, 0, lft(3)));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 1, 1, 0, lft(2)));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 1, 0, lft(2)));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 1, 1, 0, lft(1)));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 1, 0, lft(1)));
`ifdef ROUND_TIMER_EN
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 1, 0, 1, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 0, 1, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 1, 0, 0, 1, 0, 6'd3));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 1, 0, 6'd3));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 1, 1, 0, 6'd2));
`else
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 1, 1, 0, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 1, 0, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 1, 0, 1, 1, 0, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 0, 1, 0, 6'd0));
    tbl.push_back(mk(1, 1, 2'b01, 0, 0, 1, 1, 0, 6'd0));
`endif
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 0, 0, 0, 6'd0));
    tbl.push_back(mk(1, 0, 2'b01, 0, 0, 0, 0, 0, 6'd0));

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].r, tbl[i].ul, tbl[i].sp, tbl[i].st, tbl[i].pa,
          tbl[i].et, tbl[i].eb, tbl[i].ed, tbl[i].el, $sformatf("tbl[%0d]", i));
    end

    // Speed 11 maps to the normal period; a later change to 01 must not matter.
    cyc(1, 1, 2'b11, 0, 0, 0, 0, 0, 6'd0, "latch11");
    n = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) cyc(1, 1, 2'b01, 0, 0, 0, 0, 0, 6'd0, "armed_wait");
    cyc(1, 1, 2'b01, 1, 0, 0, 1, 0, lft(3), "start11");
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 1, 2'b01, 0, 0, logic'(k % 4 == 0), 1, 0, lft(3 - k / 4), $sformatf("spacing11_k%0d", k));
    end
    cyc(1, 0, 2'b01, 0, 0, 0, 0, 0, 6'd0, "drop11");

    // Speed 00: pause after two divider counts, then pause exactly on the terminal count.
    cyc(1, 1, 2'b00, 0, 0, 0, 0, 0, 6'd0, "latch00");
    cyc(1, 1, 2'b00, 1, 0, 0, 1, 0, lft(3), "start00");
    cyc(1, 1, 2'b00, 0, 0, 0, 1, 0, lft(3), "count00_1");
    cyc(1, 1, 2'b00, 0, 0, 0, 1, 0, lft(3), "count00_2");
    for (int i = 0; i < 5; i++) cyc(1, 1, 2'b00, 0, 1, 0, 1, 0, lft(3), $sformatf("paused_%0d", i));
    cyc(1, 1, 2'b00, 0, 0, 0, 1, 0, lft(3), "resume");
    cyc(1, 1, 2'b00, 0, 0, 0, 1, 0, lft(3), "resume_p1");
    cyc(1, 1, 2'b00, 0, 0, 1, 1, 0, lft(2), "tick_after_pause");
    for (int i = 1; i <= 3; i++) cyc(1, 1, 2'b00, 0, 0, 0, 1, 0, lft(2), $sformatf("count00b_%0d", i));
    cyc(1, 1, 2'b00, 0, 1, 0, 1, 0, lft(2), "pause_beats_tick");
    cyc(1, 1, 2'b00, 0, 0, 0, 1, 0, lft(2), "resume2");
    cyc(1, 1, 2'b00, 0, 0, 1, 1, 0, lft(1), "tick_after_resume2");

    // Reset on the edge where a tick would fire; start alone must not restart.
    for (int i = 1; i <= 3; i++) cyc(1, 1, 2'b00, 0, 0, 0, 1, 0, lft(1), $sformatf("pre_reset_%0d", i));
    cyc(0, 1, 2'b00, 0, 0, 0, 0, 0, 6'd0, "mid_reset");
    cyc(1, 0, 2'b00, 1, 0, 0, 0, 0, 6'd0, "start_no_userlog");
    cyc(1, 0, 2'b00, 0, 0, 0, 0, 0, 6'd0, "still_idle");
    cyc(1, 1, 2'b10, 0, 0, 0, 0, 0, 6'd0, "relatch");
    cyc(1, 1, 2'b10, 1, 0, 0, 1, 0, lft(3), "restart_after_reset");
    cyc(1, 1, 2'b10, 0, 0, 0, 1, 0, lft(3), "count_after_reset");
    cyc(1, 1, 2'b10, 0, 0, 1, 1, 0, lft(2), "tick_after_reset");
    cyc(1, 0, 2'b10, 0, 0, 0, 0, 0, 6'd0, "drop_mid_run");

`ifndef ROUND_TIMER_EN
    // Free-running at speed 01: a tick every 3 cycles, never a round end.
    nt = 0;
    cyc(1, 1, 2'b01, 0, 0, 0, 0, 0, 6'd0, "latch01");
    cyc(1, 1, 2'b01, 1, 0, 0, 1, 0, 6'd0, "start01");
    for (int k = 1; k <= 60; k++) begin
      cyc(1, 1, 2'b01, 0, 0, logic'(k % 3 == 0), 1, 0, 6'd0, $sformatf("free01_k%0d", k));
      if (tick === 1'b1) nt++;
    end
    total++;
    if (nt != 20) begin
      bad++;
      $display("FAIL free01_count: got %0d ticks, expected 20", nt);
    end
`else
    nt = 0;
    cyc(1, 1, 2'b01, 0, 0, 0, 0, 0, 6'd0, "latch01");
    cyc(1, 1, 2'b01, 1, 0, 0, 1, 0, 6'd3, "start01");
    for (int k = 1; k <= 12; k++) begin
      cyc(1, 1, 2'b01, 0, 0, logic'(k % 3 == 0 && k <= 9), logic'(k < 9),
          logic'(k >= 9), 6'(k >= 9 ? 0 : 3 - k / 3), $sformatf("round01_k%0d", k));
      if (tick === 1'b1) nt++;
    end
    total++;
    if (nt != 3) begin
      bad++;
      $display("FAIL round01_count: got %0d ticks, expected 3", nt);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
